// File: rtl/camera_mem_pkg.sv
// Shared types and constants for the frame RAM read arbiter.
//   owner_t : which requester a read belongs to
//   tag_t   : per-read tracking tag carried down the read pipeline
package camera_mem_pkg;

    // Cycles from the RAM sampling ram_rd/ram_addr to ram_q being valid
    localparam int unsigned RAM_READ_LATENCY = 1;
    // Issue register stage plus RAM latency
    localparam int unsigned ARB_PIPE_DEPTH   = RAM_READ_LATENCY + 1;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_UNL  = 2'd1,
        OWN_SCAN = 2'd2
    } owner_t;

    // owner == OWN_NONE marks an empty slot
    typedef struct packed {
        owner_t owner;
        logic   lane;   // byte lane for unloader reads (1 = ram_q[15:8])
        logic   oor;    // address beyond the populated RAM
    } tag_t;

    localparam tag_t TAG_IDLE = '{owner: OWN_NONE, lane: 1'b0, oor: 1'b0};

endpackage

// File: rtl/frame_read_arbiter.sv
// Frame RAM read-port arbiter: APF unloader byte reads versus video scanout word reads.
// Unloader reads (on a rising edge of read_en) always win; scanout is granted otherwise.
// Results return two clocks after the issuing edge.
// Ports:
//   clk_memory, reset            clock, synchronous active-high reset
//   read_en, read_addr           unloader strobe (level) and byte address
//   read_data                    returned unloader byte, held until the next unloader result
//   scan_req, scan_addr          scanout request and word address
//   scan_grant                   combinational: request accepted at the coming edge
//   scan_data, scan_valid        returned scanout word and its one-cycle valid pulse
//   ram_rd, ram_addr, ram_q      external synchronous RAM read port
//   stall_count                  saturating count of denied scanout cycles
module frame_read_arbiter
    import camera_mem_pkg::*;
#(
    parameter int unsigned ADDRESS_SIZE   = 28,
    parameter int unsigned RAM_ADDR_WIDTH = 13,
    parameter int unsigned RAM_WORDS      = 7168,
    parameter logic [7:0]  FILL_BYTE      = 8'h00
) (
    input  logic                      clk_memory,
    input  logic                      reset,
    input  logic                      read_en,
    input  logic [ADDRESS_SIZE-1:0]   read_addr,
    output logic [7:0]                read_data,
    input  logic                      scan_req,
    input  logic [RAM_ADDR_WIDTH-1:0] scan_addr,
    output logic                      scan_grant,
    output logic [15:0]               scan_data,
    output logic                      scan_valid,
    output logic                      ram_rd,
    output logic [RAM_ADDR_WIDTH-1:0] ram_addr,
    input  logic [15:0]               ram_q,
    output logic [7:0]                stall_count
);

    localparam logic [ADDRESS_SIZE-2:0] UNL_LIMIT  = (ADDRESS_SIZE-1)'(RAM_WORDS);
    // One extra bit so RAM_WORDS == 2**RAM_ADDR_WIDTH still compares correctly
    localparam logic [RAM_ADDR_WIDTH:0] SCAN_LIMIT = (RAM_ADDR_WIDTH+1)'(RAM_WORDS);

    logic prev_read_en;
    logic unl_edge;
    logic unl_oor;
    logic scan_oor;
    tag_t issue_tag;
    tag_t tail_tag;
    tag_t tag_pipe [ARB_PIPE_DEPTH];

    // Request decode and arbitration for the coming edge
    always_comb begin
        unl_edge   = read_en && !prev_read_en;
        unl_oor    = read_addr[ADDRESS_SIZE-1:1] >= UNL_LIMIT;
        scan_oor   = {1'b0, scan_addr} >= SCAN_LIMIT;
        scan_grant = scan_req && !unl_edge && !reset;
        issue_tag  = TAG_IDLE;
        if (unl_edge) begin
            issue_tag = '{owner: OWN_UNL, lane: read_addr[0], oor: unl_oor};
        end else if (scan_grant) begin
            issue_tag = '{owner: OWN_SCAN, lane: 1'b0, oor: scan_oor};
        end
    end

    // Tag of the read whose RAM data is on ram_q this cycle
    always_comb begin
        tail_tag = tag_pipe[ARB_PIPE_DEPTH-1];
    end

    // Edge detector; during reset it tracks read_en so an edge coincident with reset is consumed
    always_ff @(posedge clk_memory) begin
        prev_read_en <= read_en;
    end

    // RAM issue, tag pipeline and stall counter
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            ram_rd      <= 1'b0;
            ram_addr    <= '0;
            stall_count <= '0;
            for (int unsigned i = 0; i < ARB_PIPE_DEPTH; i++) begin
                tag_pipe[i] <= TAG_IDLE;
            end
        end else begin
            ram_rd <= 1'b0;
            if (unl_edge) begin
                if (!unl_oor) begin
                    ram_rd   <= 1'b1;
                    ram_addr <= read_addr[RAM_ADDR_WIDTH:1];
                end
                if (scan_req && stall_count != 8'hFF) begin
                    stall_count <= stall_count + 8'd1;
                end
            end else if (scan_grant) begin
                ram_rd   <= 1'b1;
                ram_addr <= scan_addr;
            end
            tag_pipe[0] <= issue_tag;
            for (int unsigned i = 1; i < ARB_PIPE_DEPTH; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Result capture from ram_q, steered by the tail tag
    always_ff @(posedge clk_memory) begin
        if (reset) begin
            read_data  <= '0;
            scan_data  <= '0;
            scan_valid <= 1'b0;
        end else begin
            scan_valid <= 1'b0;
            case (tail_tag.owner)
                OWN_UNL: begin
                    if (tail_tag.oor) begin
                        read_data <= FILL_BYTE;
                    end else begin
                        read_data <= tail_tag.lane ? ram_q[15:8] : ram_q[7:0];
                    end
                end
                OWN_SCAN: begin
                    scan_valid <= 1'b1;
                    scan_data  <= tail_tag.oor ? 16'h0000 : ram_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_frame_read_arbiter.sv
// Self-checking bench for frame_read_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_frame_read_arbiter;

    localparam int unsigned WORDS = 7168;
    localparam logic [7:0]  FILL  = 8'h00;

    logic        clk_memory = 1'b0;
    logic        reset      = 1'b1;
    logic        read_en    = 1'b0;
    logic [27:0] read_addr  = '0;
    logic [7:0]  read_data;
    logic        scan_req   = 1'b0;
    logic [12:0] scan_addr  = '0;
    logic        scan_grant;
    logic [15:0] scan_data;
    logic        scan_valid;
    logic        ram_rd;
    logic [12:0] ram_addr;
    logic [15:0] ram_q      = '0;
    logic [7:0]  stall_count;

    always #5 clk_memory = ~clk_memory;

    frame_read_arbiter dut (
        .clk_memory  (clk_memory),
        .reset       (reset),
        .read_en     (read_en),
        .read_addr   (read_addr),
        .read_data   (read_data),
        .scan_req    (scan_req),
        .scan_addr   (scan_addr),
        .scan_grant  (scan_grant),
        .scan_data   (scan_data),
        .scan_valid  (scan_valid),
        .ram_rd      (ram_rd),
        .ram_addr    (ram_addr),
        .ram_q       (ram_q),
        .stall_count (stall_count)
    );

    // External synchronous RAM
    logic [15:0] mem [0:8191];
    always @(posedge clk_memory) if (ram_rd) ram_q <= mem[ram_addr];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: expected registered outputs after the latest edge, plus pending results
    typedef struct {
        int          due;
        bit          is_scan;
        logic [15:0] val;
    } res_t;
    res_t        pend[$];
    bit          m_prev;
    logic [7:0]  m_stall, m_rdata;
    logic [15:0] m_sdata;
    bit          m_svalid, m_ram_rd, m_addr_chk, m_sdata_chk;
    logic [12:0] m_ram_addr;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] unl_byte(input logic [27:0] a);
        logic [15:0] w;
        if ((a >> 1) >= 28'(WORDS)) return FILL;
        w = mem[a[13:1]];
        return a[0] ? w[15:8] : w[7:0];
    endfunction

    function automatic logic [15:0] scan_word(input logic [12:0] a);
        if (32'(a) >= WORDS) return 16'h0000;
        return mem[a];
    endfunction

    // One clock: drive inputs, check outputs of the previous edge and the grant, advance the model
    task automatic step(input bit rst, input bit ren, input logic [27:0] raddr,
                        input bit sreq, input logic [12:0] saddr, output bit granted);
        bit edge_now;
        reset = rst; read_en = ren; read_addr = raddr; scan_req = sreq; scan_addr = saddr;
        @(negedge clk_memory);
        check("ram_rd", 32'(ram_rd), 32'(m_ram_rd));
        if (m_addr_chk) check("ram_addr", 32'(ram_addr), 32'(m_ram_addr));
        check("read_data", 32'(read_data), 32'(m_rdata));
        check("scan_valid", 32'(scan_valid), 32'(m_svalid));
        if (m_sdata_chk) check("scan_data", 32'(scan_data), 32'(m_sdata));
        check("stall_count", 32'(stall_count), 32'(m_stall));
        edge_now = ren && !m_prev;
        granted  = sreq && !rst && !edge_now;
        check("scan_grant", 32'(scan_grant), 32'(granted));
        cyc++;
        if (rst) begin
            m_prev = ren;
            pend.delete();
            m_stall = '0; m_rdata = '0; m_sdata = '0; m_svalid = 0;
            m_ram_rd = 0; m_ram_addr = '0; m_addr_chk = 1; m_sdata_chk = 1;
        end else begin
            m_prev = ren;
            m_svalid = 0; m_addr_chk = 0; m_sdata_chk = 0; m_ram_rd = 0;
            while (pend.size() > 0 && pend[0].due == cyc) begin
                if (pend[0].is_scan) begin
                    m_sdata = pend[0].val; m_svalid = 1; m_sdata_chk = 1;
                end else begin
                    m_rdata = pend[0].val[7:0];
                end
                void'(pend.pop_front());
            end
            if (edge_now) begin
                if ((raddr >> 1) < 28'(WORDS)) begin
                    m_ram_rd = 1; m_ram_addr = raddr[13:1]; m_addr_chk = 1;
                end
                pend.push_back('{due: cyc + 2, is_scan: 0, val: {8'h00, unl_byte(raddr)}});
                if (sreq && m_stall != 8'hFF) m_stall++;
            end else if (sreq) begin
                m_ram_rd = 1; m_ram_addr = saddr; m_addr_chk = 1;
                pend.push_back('{due: cyc + 2, is_scan: 1, val: scan_word(saddr)});
            end
        end
        @(posedge clk_memory);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g;
        int n, cnt, cnt2;
        bit ren, sreq;
        int hold;
        logic [27:0] raddr;
        logic [12:0] saddr;

        for (int i = 0; i < 8192; i++) mem[i] = 16'($urandom);
        mem[5] = 16'hBEEF;
        mem[3] = 16'hA55A;

        repeat (2) @(posedge clk_memory);
        #1;
        m_prev = 0; pend.delete();
        m_stall = '0; m_rdata = '0; m_sdata = '0; m_svalid = 0;
        m_ram_rd = 0; m_ram_addr = '0; m_addr_chk = 1; m_sdata_chk = 1;

        // Reset state
        step(1, 0, 0, 0, 0, g);
        check("rst read_data", 32'(read_data), 32'h0);
        check("rst stall_count", 32'(stall_count), 32'h0);

        // Unloader read of word 5, high lane
        step(0, 1, 28'd11, 0, 0, g);
        check("unl ram_rd", 32'(ram_rd), 32'h1);
        check("unl ram_addr", 32'(ram_addr), 32'h5);
        step(0, 1, 28'd11, 0, 0, g);
        step(0, 1, 28'd11, 0, 0, g);
        check("unl read_data", 32'(read_data), 32'hBE);
        step(0, 1, 28'd11, 0, 0, g);
        check("unl hold", 32'(read_data), 32'hBE);
        step(0, 0, 28'd11, 0, 0, g);

        // Level hold: one access for four high cycles
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            step(0, i < 4, 28'd10, 0, 0, g);
            cnt += int'(ram_rd);
        end
        check("level pulses", 32'(cnt), 32'd1);
        check("level read_data", 32'(read_data), 32'hEF);

        // Conflict: unloader edge beats a scan request
        step(0, 1, 28'd7, 1, 13'd3, g);
        check("conf grant0", 32'(g), 32'h0);
        check("conf stall", 32'(stall_count), 32'h1);
        step(0, 1, 28'd7, 1, 13'd3, g);
        check("conf grant1", 32'(g), 32'h1);
        step(0, 0, 28'd7, 0, 0, g);
        check("conf unl byte", 32'(read_data), 32'hA5);
        step(0, 0, 28'd7, 0, 0, g);
        check("conf scan_valid", 32'(scan_valid), 32'h1);
        check("conf scan_data", 32'(scan_data), 32'hA55A);

        // Out-of-range unloader read
        step(0, 1, 28'(2 * WORDS), 0, 0, g);
        check("oor ram_rd", 32'(ram_rd), 32'h0);
        step(0, 1, 28'(2 * WORDS), 0, 0, g);
        step(0, 0, 28'(2 * WORDS), 0, 0, g);
        check("oor fill", 32'(read_data), 32'(FILL));

        // Streaming scan reads on words 0..9
        n = 0; cnt = 0; cnt2 = 0;
        for (int i = 0; i < 13; i++) begin
            step(0, 0, 0, n < 10, 13'(n), g);
            if (g) begin n++; cnt++; end
            if (scan_valid) begin
                check("stream data", 32'(scan_data), 32'(mem[cnt2]));
                cnt2++;
            end
        end
        check("stream grants", 32'(cnt), 32'd10);
        check("stream valids", 32'(cnt2), 32'd10);

        // Reset one cycle after a grant
        step(0, 0, 0, 1, 13'd4, g);
        step(1, 0, 0, 0, 0, g);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 0, g);
            cnt += int'(scan_valid);
        end
        check("rst kill valid", 32'(cnt), 32'd0);
        check("rst stall zero", 32'(stall_count), 32'h0);
        check("rst scan_data", 32'(scan_data), 32'h0);

        // read_en rising together with reset is not replayed afterwards
        step(1, 1, 28'd11, 0, 0, g);
        cnt = 0;
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 28'd11, 0, 0, g);
            cnt += int'(ram_rd);
        end
        check("rst edge eaten", 32'(cnt), 32'd0);
        step(0, 0, 0, 0, 0, g);

        // Stall counter saturation
        for (int i = 0; i < 270; i++) begin
            step(0, 1, 28'd2, 1, 13'd1, g);
            step(0, 0, 28'd2, 1, 13'd1, g);
        end
        check("stall sat", 32'(stall_count), 32'hFF);
        step(1, 0, 0, 0, 0, g);

        // Random traffic
        ren = 0; hold = 0; raddr = '0; sreq = 0; saddr = '0; g = 0;
        for (int i = 0; i < 3000; i++) begin
            if (hold > 0) begin
                hold--;
            end else begin
                if (!ren) raddr = ($urandom % 4 != 0) ? 28'($urandom % (2 * WORDS))
                                                      : 28'($urandom);
                ren  = ($urandom % 2 == 0);
                hold = int'($urandom_range(0, 4));
            end
            if (!sreq || g) begin
                sreq  = ($urandom % 3 != 0);
                saddr = ($urandom % 10 == 0) ? 13'($urandom_range(WORDS, 8191))
                                             : 13'($urandom % WORDS);
            end
            step($urandom % 300 == 0, ren, raddr, sreq, saddr, g);
            if (reset) g = 1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
